// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults, also used by decode and writeback.
// Holds the init-state encoding and the initial-value helper.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NRD_DEF   = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Mode 0 clears every entry; mode 1 loads each entry with its own index.
    function automatic logic [31:0] init_val(input int unsigned k, input int mode);
        return (mode == 0) ? 32'd0 : 32'(k);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bus: one write port plus NRD packed read ports and init status.
// master = decode/writeback side, slave = register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = $clog2(DEPTH_DEF),
    parameter int NRD  = NRD_DEF
);
    logic                 reg_write;
    logic [AW-1:0]        write_reg;
    logic [XLEN-1:0]      write_data;
    logic [NRD*AW-1:0]    read_reg;
    logic [NRD*XLEN-1:0]  read_data;
    logic                 init_busy;

    modport master (
        output reg_write, write_reg, write_data, read_reg,
        input  read_data, init_busy
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg,
        output read_data, init_busy
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: range check, zero-register and busy masking.
// With REGFILE_BYPASS_EN defined, an accepted same-cycle write is forwarded.
module regfile_rd_port #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] mem_i [DEPTH],
    input  logic            busy_i,
    input  logic            wr_vld_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_dat_i,
    output logic [XLEN-1:0] rd_dat_o
);
    logic            in_range;
    logic            is_zero;
    logic [XLEN-1:0] rd_raw;

    assign in_range = (32'(rd_addr_i) < DEPTH);
    assign is_zero  = (ZERO_REG != 0) && (rd_addr_i == '0);

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_vld_i, wr_addr_i, wr_dat_i};
`endif

    always_comb begin
        rd_raw = '0;
        if (in_range) begin
            rd_raw = mem_i[rd_addr_i];
        end
`ifdef REGFILE_BYPASS_EN
        // wr_vld_i already excludes CLEAR, out-of-range and zero-register writes.
        if (wr_vld_i && (wr_addr_i == rd_addr_i)) begin
            rd_raw = wr_dat_i;
        end
`endif
        rd_dat_o = (busy_i || !in_range || is_zero) ? '0 : rd_raw;
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with a reset-driven init sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = $clog2(DEPTH),
    parameter int NRD       = NRD_DEF,
    parameter int INIT_MODE = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam logic [0:0]    S_CLEAR  = 1'(CLEAR);
    localparam logic [0:0]    S_READY  = 1'(READY);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic clearing;
    logic wr_in_range;
    logic wr_accept;

    assign clearing    = (state_q == S_CLEAR);
    assign wr_in_range = (32'(bus.write_reg) < DEPTH);
    assign wr_accept   = !clearing && bus.reg_write && wr_in_range &&
                         !((ZERO_REG != 0) && (bus.write_reg == '0));

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (clearing) begin
            if (clr_idx_q == LAST_IDX) begin
                state_d   = S_READY;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The sweep owns the array while clearing; writeback only gets it in READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem_q[clr_idx_q] <= XLEN'(init_val(32'(clr_idx_q), INIT_MODE));
            end else if (wr_accept) begin
                mem_q[bus.write_reg] <= bus.write_data;
            end
        end
    end

    assign bus.init_busy = clearing;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rd_port #(
            .XLEN     (XLEN),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rd_addr_i (bus.read_reg[i*AW +: AW]),
            .mem_i     (mem_q),
            .busy_i    (clearing),
            .wr_vld_i  (wr_accept),
            .wr_addr_i (bus.write_reg),
            .wr_dat_i  (bus.write_data),
            .rd_dat_o  (bus.read_data[i*XLEN +: XLEN])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Two register files (32x2 zero-reg, 24x3 no zero-reg) against an array model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XL = 32;
    localparam int AW = 5;
    localparam int D0 = 32;
    localparam int N0 = 2;
    localparam int D1 = 24;
    localparam int N1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   ready = 1'b0;

    logic [XL-1:0] m0 [D0];
    logic [XL-1:0] m1 [D1];

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XL), .AW(AW), .NRD(N0)) rf0 ();
    regfile_mp_if #(.XLEN(XL), .AW(AW), .NRD(N1)) rf1 ();

    regfile_mp #(.XLEN(XL), .DEPTH(D0), .NRD(N0), .INIT_MODE(1), .ZERO_REG(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (rf0)
    );

    regfile_mp #(.XLEN(XL), .DEPTH(D1), .NRD(N1), .INIT_MODE(1), .ZERO_REG(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (rf1)
    );

    function automatic logic [XL-1:0] exp0(input int a);
        if (a >= D0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rf0.reg_write && int'(rf0.write_reg) == a) return rf0.write_data;
`endif
        return m0[a];
    endfunction

    function automatic logic [XL-1:0] exp1(input int a);
        if (a >= D1) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rf1.reg_write && int'(rf1.write_reg) == a) return rf1.write_data;
`endif
        return m1[a];
    endfunction

    task automatic drive_idle();
        rf0.reg_write = 1'b0; rf0.write_reg = '0; rf0.write_data = '0; rf0.read_reg = '0;
        rf1.reg_write = 1'b0; rf1.write_reg = '0; rf1.write_data = '0; rf1.read_reg = '0;
    endtask

    task automatic init_models();
        for (int k = 0; k < D0; k++) m0[k] = XL'(k);
        for (int k = 0; k < D1; k++) m1[k] = XL'(k);
    endtask

    // Advance one edge; the model takes every write the rules accept.
    task automatic step();
        @(posedge clk);
        if (ready && !rst) begin
            if (rf0.reg_write && rf0.write_reg != '0) m0[rf0.write_reg] = rf0.write_data;
            if (rf1.reg_write && int'(rf1.write_reg) < D1) m1[rf1.write_reg] = rf1.write_data;
        end
        #1;
    endtask

    // Runs the init sweep with rst low; counts edges until each init_busy falls.
    task automatic run_init(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int cyc = 1; cyc <= 100 && (c0 == 0 || c1 == 0); cyc++) begin
            rf0.reg_write = (cyc <= D1); rf0.write_reg = 5'd3; rf0.write_data = '1;
            rf1.reg_write = (cyc <= D1); rf1.write_reg = 5'd3; rf1.write_data = '1;
            rf0.read_reg = N0*AW'($urandom);
            rf1.read_reg = N1*AW'($urandom);
            #1;
            if (cyc <= D0) begin
                checks++;
                if (rf0.read_data !== '0) begin
                    failures++;
                    $display("FAIL clear_read0 cyc=%0d: got %0h expected 0", cyc, rf0.read_data);
                end
            end
            if (cyc <= D1) begin
                checks++;
                if (rf1.read_data !== '0) begin
                    failures++;
                    $display("FAIL clear_read1 cyc=%0d: got %0h expected 0", cyc, rf1.read_data);
                end
            end
            step();
            if (c0 == 0 && rf0.init_busy !== 1'b1) c0 = cyc;
            if (c1 == 0 && rf1.init_busy !== 1'b1) c1 = cyc;
        end
        drive_idle();
        init_models();
        ready = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        ready = 1'b0;
        rf0.read_reg[0 +: AW] = 5'd5;
        rf0.read_reg[AW +: AW] = 5'd31;
        rf1.read_reg = {5'd23, 5'd1, 5'd2};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rf0.init_busy !== 1'b1 || rf1.init_busy !== 1'b1) begin
                failures++;
                $display("FAIL reset_busy: got %b/%b expected 1/1", rf0.init_busy, rf1.init_busy);
            end
            checks++;
            if (rf0.read_data !== '0 || rf1.read_data !== '0) begin
                failures++;
                $display("FAIL reset_read: got %0h/%0h expected 0/0", rf0.read_data, rf1.read_data);
            end
        end
    endtask

    task automatic test_init_defaults();
        int c0, c1;
        rst = 1'b0;
        run_init(c0, c1);
        checks++;
        if (c0 != D0) begin
            failures++;
            $display("FAIL init_len0: got %0d edges expected %0d", c0, D0);
        end
        checks++;
        if (c1 != D1) begin
            failures++;
            $display("FAIL init_len1: got %0d edges expected %0d", c1, D1);
        end
        rf0.read_reg[0 +: AW] = 5'd5;
        rf0.read_reg[AW +: AW] = 5'd31;
        rf1.read_reg = {5'd23, 5'd23, 5'd23};
        #1;
        checks++;
        if (rf0.read_data !== {32'd31, 32'd5}) begin
            failures++;
            $display("FAIL init_vals0: got %0h expected 1f_00000005", rf0.read_data);
        end
        checks++;
        if (rf1.read_data !== {32'd23, 32'd23, 32'd23}) begin
            failures++;
            $display("FAIL three_ports23: got %0h expected 23 x3", rf1.read_data);
        end
        step();
    endtask

    task automatic test_write_read();
        logic [XL-1:0] exp_same;
        rf0.reg_write = 1'b1; rf0.write_reg = 5'd7; rf0.write_data = 32'hDEADBEEF;
        rf0.read_reg[0 +: AW] = 5'd7;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'd7;
`endif
        #1;
        checks++;
        if (rf0.read_data[0 +: XL] !== exp_same) begin
            failures++;
            $display("FAIL wr_same_cycle: got %0h expected %0h", rf0.read_data[0 +: XL], exp_same);
        end
        step();
        rf0.reg_write = 1'b0;
        #1;
        checks++;
        if (rf0.read_data[0 +: XL] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_then_rd: got %0h expected deadbeef", rf0.read_data[0 +: XL]);
        end
    endtask

    task automatic test_zero_reg();
        logic [XL-1:0] exp_same1;
        rf0.reg_write = 1'b1; rf0.write_reg = 5'd0; rf0.write_data = 32'h1234;
        rf1.reg_write = 1'b1; rf1.write_reg = 5'd0; rf1.write_data = 32'h1234;
        rf0.read_reg = '0;
        rf1.read_reg = '0;
`ifdef REGFILE_BYPASS_EN
        exp_same1 = 32'h1234;
`else
        exp_same1 = 32'h0;
`endif
        #1;
        checks++;
        if (rf0.read_data !== '0) begin
            failures++;
            $display("FAIL zero_same_cycle: got %0h expected 0", rf0.read_data);
        end
        checks++;
        if (rf1.read_data[0 +: XL] !== exp_same1) begin
            failures++;
            $display("FAIL nozero_same_cycle: got %0h expected %0h", rf1.read_data[0 +: XL], exp_same1);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (rf0.read_data !== '0) begin
            failures++;
            $display("FAIL zero_reg_read: got %0h expected 0", rf0.read_data);
        end
        checks++;
        if (rf1.read_data !== {3{32'h1234}}) begin
            failures++;
            $display("FAIL nozero_reg_read: got %0h expected 1234 x3", rf1.read_data);
        end
    endtask

    task automatic test_odd_depth();
        rf1.reg_write = 1'b1; rf1.write_reg = 5'd30; rf1.write_data = 32'hCAFEF00D;
        rf1.read_reg = {5'd6, 5'd31, 5'd30};
        #1;
        checks++;
        if (rf1.read_data[0 +: 2*XL] !== '0) begin
            failures++;
            $display("FAIL oor_read_same: got %0h expected 0", rf1.read_data[0 +: 2*XL]);
        end
        step();
        drive_idle();
        rf1.read_reg = {5'd6, 5'd31, 5'd30};
        #1;
        checks++;
        if (rf1.read_data !== {exp1(6), 64'h0}) begin
            failures++;
            $display("FAIL oor_write_ignored: got %0h expected %0h", rf1.read_data, {exp1(6), 64'h0});
        end
    endtask

    task automatic test_bypass();
        logic [XL-1:0] exp_same;
        rf0.reg_write = 1'b1; rf0.write_reg = 5'd9; rf0.write_data = 32'hA5A5A5A5;
        rf0.read_reg[AW +: AW] = 5'd9;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'd9;
`endif
        #1;
        checks++;
        if (rf0.read_data[XL +: XL] !== exp_same) begin
            failures++;
            $display("FAIL bypass_reg9: got %0h expected %0h", rf0.read_data[XL +: XL], exp_same);
        end
        step();
        rf0.write_reg = 5'd0;
        rf0.read_reg[AW +: AW] = 5'd0;
        #1;
        checks++;
        if (rf0.read_data[XL +: XL] !== '0) begin
            failures++;
            $display("FAIL bypass_reg0: got %0h expected 0", rf0.read_data[XL +: XL]);
        end
        step();
        drive_idle();
    endtask

    task automatic test_reset_mid_clear();
        int c0, c1;
        rst = 1'b1;
        ready = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rf0.reg_write = 1'b1; rf0.write_reg = 5'd3; rf0.write_data = 32'h55;
            step();
        end
        checks++;
        if (rf0.init_busy !== 1'b1 || rf1.init_busy !== 1'b1) begin
            failures++;
            $display("FAIL midclear_busy: got %b/%b expected 1/1", rf0.init_busy, rf1.init_busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_init(c0, c1);
        checks++;
        if (c0 != D0 || c1 != D1) begin
            failures++;
            $display("FAIL midclear_len: got %0d/%0d expected %0d/%0d", c0, c1, D0, D1);
        end
        rf0.read_reg[0 +: AW] = 5'd3;
        rf1.read_reg[0 +: AW] = 5'd3;
        #1;
        checks++;
        if (rf0.read_data[0 +: XL] !== 32'd3 || rf1.read_data[0 +: XL] !== 32'd3) begin
            failures++;
            $display("FAIL midclear_drop: got %0h/%0h expected 3/3",
                     rf0.read_data[0 +: XL], rf1.read_data[0 +: XL]);
        end
        step();
    endtask

    task automatic test_random();
        int a;
        for (int n = 0; n < 400; n++) begin
            rf0.reg_write = 1'($urandom_range(0, 1)); rf0.write_reg = AW'($urandom);
            rf0.write_data = $urandom;
            rf1.reg_write = 1'($urandom_range(0, 1)); rf1.write_reg = AW'($urandom);
            rf1.write_data = $urandom;
            rf0.read_reg = N0*AW'($urandom);
            rf1.read_reg = N1*AW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rf0.read_reg[0 +: AW] = rf0.write_reg;
                rf1.read_reg[AW +: AW] = rf1.write_reg;
            end
            #1;
            for (int p = 0; p < N0; p++) begin
                a = int'(rf0.read_reg[p*AW +: AW]);
                checks++;
                if (rf0.read_data[p*XL +: XL] !== exp0(a)) begin
                    failures++;
                    $display("FAIL rand0 n=%0d port=%0d addr=%0d: got %0h expected %0h",
                             n, p, a, rf0.read_data[p*XL +: XL], exp0(a));
                end
            end
            for (int p = 0; p < N1; p++) begin
                a = int'(rf1.read_reg[p*AW +: AW]);
                checks++;
                if (rf1.read_data[p*XL +: XL] !== exp1(a)) begin
                    failures++;
                    $display("FAIL rand1 n=%0d port=%0d addr=%0d: got %0h expected %0h",
                             n, p, a, rf1.read_data[p*XL +: XL], exp1(a));
                end
            end
            step();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        #1;
        test_reset();
        test_init_defaults();
        test_write_read();
        test_zero_reg();
        test_odd_depth();
        test_bypass();
        test_random();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port, single-write-port register file; successor to the fixed 32x32 two-read-port file in the RISC-V datapath.
- Sits between decode (read addresses) and writeback (write port).
- Adds the following over the previous generation:
  - configurable width, depth and read-port count;
  - hardwired zero register;
  - reset-driven sequential initialisation engine with a busy flag, replacing simulation-only initial blocks;
  - optional write-to-read bypass.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; need not be a power of 2.
- AW, $clog2(DEPTH), register address width; derived, do not override.
- NRD, 2, number of read ports (1..8).
- INIT_MODE, 1, initialisation value: 0 = all zero; 1 = register k gets k (zero-extended to XLEN).
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_write  in  1  write enable.
- write_reg  in  AW  write address.
- write_data  in  XLEN  write data.
- read_reg  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW].
- read_data  out  NRD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN].
- init_busy  out  1  high while the initialisation sequence runs.

Behaviour:
- State machine: CLEAR, READY. There is no IDLE state.
- Reset:
  - A rising edge with rst=1 forces CLEAR and clr_idx=0.
  - While rst stays high, no array entry is written and clr_idx holds at 0.
  - init_busy=1 from the first edge with rst=1.
- CLEAR:
  - Each edge with rst=0 writes init_val(clr_idx) to array[clr_idx], then clr_idx++.
  - On the edge that writes clr_idx==DEPTH-1, state becomes READY and init_busy falls.
  - So init_busy stays high for exactly DEPTH edges after rst deasserts.
- Reset asserted mid-CLEAR restarts from clr_idx=0. Reset in READY re-enters CLEAR; array contents are then rewritten progressively.
- In CLEAR:
  - reg_write is ignored; the write is dropped, not queued.
  - All read_data ports return 0.
- READY write:
  - Accepted at the edge when reg_write=1 and write_reg<DEPTH, and not (ZERO_REG=1 and write_reg==0).
  - Rejected writes change nothing.
- READY read:
  - Combinational, zero latency. read_data[i] = array[read_reg[i]].
  - Returns 0 if read_reg[i]>=DEPTH, or if ZERO_REG=1 and read_reg[i]==0.
- All read ports are independent. Any number may address the same register.
- Simultaneous write and read of the same address without bypass: read returns the old value until the edge, then the new value.
- init_busy reset value is 1. read_data is 0 throughout reset and CLEAR.
- Power-up before the first reset: contents undefined, state undefined. The integrator must assert rst at least one cycle.
- No initial blocks in synthesisable RTL.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if a write is accepted this cycle (rules above) and read_reg[i]==write_reg, then read_data[i]=write_data combinationally in the same cycle. Zero-register and out-of-range masking still take priority.
- Undefined: no forwarding; read returns the stored value as in the non-bypass rule above.
- The macro has no effect during CLEAR.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum typedef (CLEAR, READY);
  - localparam-derivation helper for init value (function init_val(k, INIT_MODE));
  - default XLEN/DEPTH constants shared with decode and writeback.
- One natural sub-module: regfile_rd_port (one instance per read port via generate). It performs address-range check, zero masking, busy masking and optional bypass mux.
- Array, write logic and FSM stay in regfile_mp.

Test Plan:
1. Defaults. Hold rst=1 for 3 cycles, release. init_busy must stay high for exactly 32 edges. Afterwards, read_reg port0=5, port1=31 gives read_data 5 and 31.
2. Write then read. reg_write=1, write_reg=7, write_data=0xDEADBEEF for one cycle; then read port0=7 gives 0xDEADBEEF. Same-cycle read without the macro returns 7.
3. Zero register (ZERO_REG=1). Write 0x1234 to register 0; read register 0 gives 0. With ZERO_REG=0, read gives 0x1234.
4. Reset mid-CLEAR:
   - Release rst, wait 10 cycles, assert rst 1 cycle, release.
   - init_busy high 32 more edges.
   - reg_write attempted to register 3 during CLEAR is dropped; register 3 reads 3 after READY.
5. Odd depth and more ports (DEPTH=24, NRD=3):
   - Read address 30 gives 0. Write to address 30 is ignored.
   - All 3 ports reading register 23 return 23 simultaneously.
6. With REGFILE_BYPASS_EN:
   - Write 0xA5A5A5A5 to register 9 while port1 reads 9: read_data port1 equals 0xA5A5A5A5 in the same cycle.
   - Same stimulus to register 0 with ZERO_REG=1 returns 0.
